cpu_flags_mt: RTL and testbench

CPU_FLAGS_MT -- requirements
Module: cpu_flags_mt

---
 rtl/cpu_flags_mt_pkg.sv | 21 ++
 rtl/cpu_flags_stack.sv | 30 +++
 rtl/cpu_flags_mt.sv | 174 +++++++++++++++++
 tb/tb_cpu_flags_mt.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_flags_mt_pkg.sv
// Shared flag bit positions, condition encoding, defaults and FSM state type for cpu_flags_mt.
// No logic; constants and types only.
package cpu_flags_mt_pkg;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_ONE      = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_USER0    = 3;

    localparam int DEF_N_FLAGS   = 4;
    localparam int DEF_N_THREADS = 16;

    // Condition code 0 is "always"; code k selects flag k-1, MSB inverts.
    localparam int COND_ALWAYS   = 0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/cpu_flags_stack.sv
// Per-thread flag stack storage: N_THREADS*STACK_DEPTH words of N_FLAGS bits.
// Synchronous write, asynchronous read; contents are never reset.
// Always accepts a write; no backpressure.
module cpu_flags_stack
    import cpu_flags_mt_pkg::*;
#(
    parameter int N_FLAGS     = DEF_N_FLAGS,
    parameter int N_THREADS   = DEF_N_THREADS,
    parameter int STACK_DEPTH = 4,
    parameter int AW          = 6
) (
    input  logic               CLK,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [N_FLAGS-1:0] wr_dat,
    input  logic [AW-1:0]      rd_addr,
    output logic [N_FLAGS-1:0] rd_dat
);

    logic [N_FLAGS-1:0] mem [N_THREADS*STACK_DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/cpu_flags_mt.sv
// Multi-threaded CPU flag register with per-thread context memory, flag stack and condition evaluation.
// flags updates one cycle after a strobe; condition_is_true is combinational; stack_err pulses one cycle later.
// No backpressure: strobes are dropped while busy (post-reset memory sweep).
module cpu_flags_mt
    import cpu_flags_mt_pkg::*;
#(
    parameter int N_FLAGS     = DEF_N_FLAGS,
    parameter int N_THREADS   = DEF_N_THREADS,
    parameter int STACK_DEPTH = 4,
    parameter int COND_LEN    = 4,
    localparam int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_THREADS_MSB:0]   thread_num,
    input  logic                     load_en,
    input  logic                     save_en,
    input  logic                     set_flags,
    input  logic [N_FLAGS-1:0]       iop_flag_mask,
    input  logic [N_FLAGS-1:0]       flags_in,
    input  logic                     push_en,
    input  logic                     pop_en,
    input  logic [COND_LEN-1:0]      op_condition,
    output logic [N_FLAGS-1:0]       flags,
    output logic                     condition_is_true,
    output logic                     stack_err,
    output logic                     busy
);

    localparam int TW  = N_THREADS_MSB + 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = $clog2(STACK_DEPTH);
    localparam int EW  = N_FLAGS + SPW;
    localparam int CIW = COND_LEN - 1;

    state_t             state, state_nxt;
    logic [TW-1:0]      init_cnt;
    logic [TW-1:0]      cur_thread, thread_nxt;
    logic [SPW-1:0]     sp, sp_nxt, sp_m1;
    logic [N_FLAGS-1:0] flags_nxt, stack_rd;
    logic               run, do_load, do_push, do_pop;
    logic               push_ok, push_ovf, pop_ok, pop_unf;

    logic [EW-1:0]      ctx_mem [N_THREADS];
    logic               mem_we;
    logic [TW-1:0]      mem_waddr;
    logic [EW-1:0]      mem_wdat, ctx_rd;
    logic [CIW-1:0]     cidx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_INIT: begin
                busy = 1'b1;
                if (init_cnt == TW'(N_THREADS - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // The init sweep owns the context memory write port while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = thread_num;
        mem_wdat  = {flags, sp};
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdat  = '0;
        end else if (save_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            ctx_mem[mem_waddr] <= mem_wdat;
        end
    end

    // Load and save share thread_num, so a same-cycle load sees the live context.
    assign ctx_rd = save_en ? {flags, sp} : ctx_mem[thread_num];

    assign sp_m1 = sp - 1'b1;

    cpu_flags_stack #(
        .N_FLAGS     (N_FLAGS),
        .N_THREADS   (N_THREADS),
        .STACK_DEPTH (STACK_DEPTH),
        .AW          (TW + SIW)
    ) u_stack (
        .CLK     (CLK),
        .wr_en   (push_ok),
        .wr_addr ({cur_thread, sp[SIW-1:0]}),
        .wr_dat  (flags),
        .rd_addr ({cur_thread, sp_m1[SIW-1:0]}),
        .rd_dat  (stack_rd)
    );

    always_comb begin
        run      = (state == ST_RUN);
        do_load  = run & load_en;
        do_push  = run & push_en & ~pop_en & ~load_en;
        do_pop   = run & pop_en & ~push_en & ~load_en;
        push_ok  = do_push & (sp != SPW'(STACK_DEPTH));
        push_ovf = do_push & (sp == SPW'(STACK_DEPTH));
        pop_ok   = do_pop & (sp != '0);
        pop_unf  = do_pop & (sp == '0);

        flags_nxt  = flags;
        sp_nxt     = sp;
        thread_nxt = cur_thread;
        if (do_load) begin
            {flags_nxt, sp_nxt} = ctx_rd;
            thread_nxt          = thread_num;
        end else if (do_pop) begin
            if (pop_ok) begin
                flags_nxt = stack_rd;
                sp_nxt    = sp_m1;
            end
        end else begin
            if (push_ok) begin
                sp_nxt = sp + 1'b1;
            end
            if (run && set_flags && !push_ovf) begin
                flags_nxt = (flags & ~iop_flag_mask) | (flags_in & iop_flag_mask);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags      <= '0;
            sp         <= '0;
            cur_thread <= '0;
            stack_err  <= 1'b0;
        end else begin
            flags      <= flags_nxt;
            sp         <= sp_nxt;
            cur_thread <= thread_nxt;
            stack_err  <= push_ovf | pop_unf;
        end
    end

    always_comb begin
        cidx              = op_condition[CIW-1:0] - 1'b1;
        condition_is_true = 1'b0;
        if (op_condition == COND_LEN'(COND_ALWAYS)) begin
            condition_is_true = 1'b1;
        end else begin
            for (int i = 0; i < N_FLAGS; i++) begin
                if (cidx == CIW'(i)) begin
                    condition_is_true = flags[i] ^ op_condition[COND_LEN-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_flags_mt.sv
// Self-checking bench for cpu_flags_mt: scenario tasks drive strobes, expected {stack_err, flags}
// values go through a scoreboard queue and are compared one cycle later.
module tb_cpu_flags_mt;

    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] LD  = 5'b10000;
    localparam logic [4:0] SV  = 5'b01000;
    localparam logic [4:0] ST  = 5'b00100;
    localparam logic [4:0] PU  = 5'b00010;
    localparam logic [4:0] PO  = 5'b00001;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] thread_num;
    logic       load_en, save_en, set_flags, push_en, pop_en;
    logic [3:0] iop_flag_mask, flags_in, op_condition;
    logic [3:0] flags;
    logic       condition_is_true, stack_err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0] ctl;
        logic [3:0] th;
        logic [3:0] mask;
        logic [3:0] fin;
    } stim_t;

    stim_t      sq [$];
    logic [4:0] el [$];
    logic [4:0] exp_q [$];

    cpu_flags_mt #(
        .N_FLAGS     (4),
        .N_THREADS   (16),
        .STACK_DEPTH (4),
        .COND_LEN    (4)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .thread_num        (thread_num),
        .load_en           (load_en),
        .save_en           (save_en),
        .set_flags         (set_flags),
        .iop_flag_mask     (iop_flag_mask),
        .flags_in          (flags_in),
        .push_en           (push_en),
        .pop_en            (pop_en),
        .op_condition      (op_condition),
        .flags             (flags),
        .condition_is_true (condition_is_true),
        .stack_err         (stack_err),
        .busy              (busy)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input stim_t s);
        load_en       = s.ctl[4];
        save_en       = s.ctl[3];
        set_flags     = s.ctl[2];
        push_en       = s.ctl[1];
        pop_en        = s.ctl[0];
        thread_num    = s.th;
        iop_flag_mask = s.mask;
        flags_in      = s.fin;
    endtask

    task automatic idle();
        drive('0);
    endtask

    task automatic add(input logic [4:0] ctl, input logic [3:0] th, input logic [3:0] mask,
                       input logic [3:0] fin, input logic [4:0] e);
        sq.push_back({ctl, th, mask, fin});
        el.push_back(e);
    endtask

    task automatic test_reset();
        int n;
        int bad;
        logic [5:0] got;
        RST = 1'b1;
        idle();
        op_condition = '0;
        #12;
        got = {busy, stack_err, flags};
        n_checks++;
        if (got !== 6'b100000) $display("FAIL reset_state busy/err/flags=%b required 100000", got);
        else n_pass++;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        drive({LD | SV | ST | PU, 4'd7, 4'hF, 4'hF});
        n = 0;
        bad = 0;
        while (busy && n < 100) begin
            @(posedge CLK); #1;
            n++;
            if (flags !== 4'b0000 || stack_err !== 1'b0) bad++;
        end
        idle();
        n_checks++;
        if (n !== 16) $display("FAIL init_busy_cycles got %0d required 16", n);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL init_ignores_strobes got %0d bad cycles required 0", bad);
        else n_pass++;
        sq.delete(); el.delete();
        add(LD, 7, 0, 0, 5'b0_0000);
        add(PO, 0, 0, 0, 5'b1_0000);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL after_init[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    task automatic test_set_save_load();
        sq.delete(); el.delete();
        add(LD, 3, 0,       0,       5'b0_0000);
        add(ST, 0, 4'b0101, 4'b1111, 5'b0_0101);
        add(SV, 3, 0,       0,       5'b0_0101);
        add(LD, 5, 0,       0,       5'b0_0000);
        add(LD, 3, 0,       0,       5'b0_0101);
        add(ST, 0, 4'b1100, 4'b0011, 5'b0_0001);
        add(ST, 0, 4'b0010, 4'b0010, 5'b0_0011);
        add(LD, 3, 0,       0,       5'b0_0101);
        add(NOP, 0, 0,      0,       5'b0_0101);
        add(ST, 0, 4'b1111, 4'b0100, 5'b0_0100);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL set_save_load[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    task automatic test_condition();
        logic [3:0] ops [$] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b0111, 4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1101};
        logic       ec  [$] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < ops.size(); i++) begin
            logic [4:0] x;
            op_condition = ops[i];
            exp_q.push_back({4'b0000, ec[i]});
            #2;
            x = exp_q.pop_front();
            n_checks++;
            if (condition_is_true !== x[0])
                $display("FAIL condition op=%b got %b required %b", ops[i], condition_is_true, x[0]);
            else n_pass++;
        end
        op_condition = '0;
    endtask

    task automatic test_stack();
        sq.delete(); el.delete();
        add(LD,      1, 0,       0,       5'b0_0000);
        add(PU | ST, 0, 4'b1111, 4'b0001, 5'b0_0001);
        add(PU | ST, 0, 4'b1111, 4'b0010, 5'b0_0010);
        add(PU | ST, 0, 4'b1111, 4'b0011, 5'b0_0011);
        add(PU | ST, 0, 4'b1111, 4'b0100, 5'b0_0100);
        add(PU | ST, 0, 4'b1111, 4'b1111, 5'b1_0100);
        add(NOP,     0, 0,       0,       5'b0_0100);
        add(PO,      0, 0,       0,       5'b0_0011);
        add(PO,      0, 0,       0,       5'b0_0010);
        add(PO,      0, 0,       0,       5'b0_0001);
        add(PO,      0, 0,       0,       5'b0_0000);
        add(ST,      0, 4'b1111, 4'b1010, 5'b0_1010);
        add(PO,      0, 0,       0,       5'b1_1010);
        add(NOP,     0, 0,       0,       5'b0_1010);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL stack[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        sq.delete(); el.delete();
        add(PU | PO | ST, 0, 4'b1111, 4'b0110, 5'b0_0110);
        add(PO,           0, 0,       0,       5'b1_0110);
        add(PU,           0, 0,       0,       5'b0_0110);
        add(PO | ST,      0, 4'b1111, 4'b1111, 5'b0_0110);
        add(ST,           0, 4'b1111, 4'b1001, 5'b0_1001);
        add(LD | PO | ST, 3, 4'b1111, 4'b1111, 5'b0_0101);
        add(PO,           0, 0,       0,       5'b1_0101);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL priority[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        sq.delete(); el.delete();
        add(LD,      2, 0,       0,       5'b0_0000);
        add(ST,      0, 4'b1111, 4'b1001, 5'b0_1001);
        add(LD | SV, 2, 0,       0,       5'b0_1001);
        add(ST,      0, 4'b1111, 4'b0110, 5'b0_0110);
        add(SV,      4, 0,       0,       5'b0_0110);
        add(LD,      2, 0,       0,       5'b0_1001);
        add(LD,      4, 0,       0,       5'b0_0110);
        add(LD,      3, 0,       0,       5'b0_0101);
        add(LD | SV, 3, 0,       0,       5'b0_0101);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL back_to_back[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    task automatic test_reset_run();
        int n;
        logic [5:0] got;
        sq.delete(); el.delete();
        add(LD, 6, 0,       0,       5'b0_0000);
        add(ST, 0, 4'b1111, 4'b0111, 5'b0_0111);
        add(PU, 0, 0,       0,       5'b0_0111);
        add(PU, 0, 0,       0,       5'b0_0111);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL pre_reset[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
        #2;
        RST = 1'b1;
        #1;
        got = {busy, stack_err, flags};
        n_checks++;
        if (got !== 6'b100000) $display("FAIL async_reset busy/err/flags=%b required 100000", got);
        else n_pass++;
        #3;
        RST = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        n_checks++;
        if (n !== 16) $display("FAIL reinit_busy_cycles got %0d required 16", n);
        else n_pass++;
        sq.delete(); el.delete();
        add(LD, 6, 0, 0, 5'b0_0000);
        add(PO, 0, 0, 0, 5'b1_0000);
        add(LD, 3, 0, 0, 5'b0_0000);
        add(LD, 2, 0, 0, 5'b0_0000);
        for (int i = 0; i < sq.size(); i++) begin
            logic [4:0] g, x;
            drive(sq[i]);
            exp_q.push_back(el[i]);
            @(posedge CLK); #1;
            idle();
            g = {stack_err, flags};
            x = exp_q.pop_front();
            n_checks++;
            if (g !== x) $display("FAIL post_reset[%0d] err/flags=%b required %b", i, g, x);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_set_save_load();
        test_condition();
        test_stack();
        test_priority();
        test_back_to_back();
        test_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
